// File: rtl/dsam_pkg.sv
// Shared definitions for the differential-sample (dsam) encoder/decoder pair.
// Holds default word/channel sizing and the channel-pointer width helper.
// No logic; imported by every dsam module.
package dsam_pkg;

    localparam int DSAM_DATA_WIDTH = 16;
    localparam int DSAM_CHANNELS   = 4;

    // Channel pointer width; at least one bit so CHANNELS==1 still has a port.
    function automatic int ptr_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/dsam_history_bank.sv
// Per-channel history register file: CHANNELS x DATA_WIDTH, one read and one write port.
// Read is combinational at addr; write lands on the clock edge.
// Ports: clk, reset (async, active-low), clear (sync wipe), wr_en, addr, wr_data, rd_data.
module dsam_history_bank
    import dsam_pkg::*;
#(
    parameter  int DATA_WIDTH = DSAM_DATA_WIDTH,
    parameter  int CHANNELS   = DSAM_CHANNELS,
    localparam int PW         = ptr_width(CHANNELS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [PW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] hist [CHANNELS];

    assign rd_data = hist[addr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < CHANNELS; c++) hist[c] <= '0;
        end else begin
            if (clear) begin
                for (int c = 0; c < CHANNELS; c++) hist[c] <= '0;
            end
            // A write in the same cycle as clear wins, so a frame can restart
            // with its first word already stored.
            if (wr_en) hist[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/dsam_decoder.sv
// Differential-sample decoder: out = in ^ last decoded word of the same interleaved channel.
// Latency 1 cycle, 1 word/cycle, no backpressure; gaps (in_valid=0) do not advance the channel.
// Ports: clk, reset (async active-low), flush, in_valid, in -> out_valid, out, ch_idx.
module dsam_decoder
    import dsam_pkg::*;
#(
    parameter  int DATA_WIDTH = DSAM_DATA_WIDTH,
    parameter  int CHANNELS   = DSAM_CHANNELS,
    localparam int PW         = ptr_width(CHANNELS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out,
    output logic [PW-1:0]         ch_idx
);

    localparam logic [PW-1:0] LAST_CH = PW'(CHANNELS - 1);

    logic [PW-1:0]         ptr;
    logic [PW-1:0]         addr;
    logic [DATA_WIDTH-1:0] hist_rd;
    logic [DATA_WIDTH-1:0] dec;

    // Explicit compare so non-power-of-two channel counts wrap correctly.
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == LAST_CH) ? '0 : p + 1'b1;
    endfunction

    // On flush the incoming word starts a new frame on channel 0 with zero history.
    assign addr = flush ? '0 : ptr;
    assign dec  = flush ? in : (in ^ hist_rd);

    dsam_history_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .CHANNELS   (CHANNELS)
    ) u_hist (
        .clk     (clk),
        .reset   (reset),
        .clear   (flush),
        .wr_en   (in_valid),
        .addr    (addr),
        .wr_data (dec),
        .rd_data (hist_rd)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            ch_idx    <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out    <= dec;
                ch_idx <= addr;
                ptr    <= wrap_inc(addr);
            end else if (flush) begin
                ptr <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dsam_decoder.sv
// Scoreboard bench for dsam_decoder: a 4-channel and a 3-channel instance.
// Stimulus pushes expected {word, channel}; negedge monitors pop and compare on out_valid,
// and check that out/ch_idx hold during idle cycles.
module tb_dsam_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        flush4, vld4, flush3, vld3;
    logic [15:0] in4, in3;
    logic        ov4, ov3;
    logic [15:0] out4, out3;
    logic [1:0]  ch4, ch3;

    dsam_decoder #(.DATA_WIDTH(16), .CHANNELS(4)) dut4 (
        .clk(clk), .reset(reset), .flush(flush4), .in_valid(vld4), .in(in4),
        .out_valid(ov4), .out(out4), .ch_idx(ch4)
    );

    dsam_decoder #(.DATA_WIDTH(16), .CHANNELS(3)) dut3 (
        .clk(clk), .reset(reset), .flush(flush3), .in_valid(vld3), .in(in3),
        .out_valid(ov3), .out(out3), .ch_idx(ch3)
    );

    typedef struct packed {
        logic [15:0] d;
        logic [1:0]  c;
    } exp_t;

    exp_t q4[$];
    exp_t q3[$];
    int total = 0;
    int bad   = 0;
    logic [15:0] last4 = '0, last3 = '0;
    logic [1:0]  lch4 = '0, lch3 = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h at %0t", name, act, want, $time);
        end
    endtask

    task automatic drive4(input logic v, input logic f, input logic [15:0] d);
        @(posedge clk);
        #1;
        vld4 = v; flush4 = f; in4 = d;
    endtask

    task automatic drive3(input logic v, input logic f, input logic [15:0] d);
        @(posedge clk);
        #1;
        vld3 = v; flush3 = f; in3 = d;
    endtask

    task automatic send4(input logic f, input logic [15:0] d, input logic [15:0] e, input logic [1:0] c);
        drive4(1'b1, f, d);
        q4.push_back('{d: e, c: c});
    endtask

    task automatic send3(input logic [15:0] d, input logic [15:0] e, input logic [1:0] c);
        drive3(1'b1, 1'b0, d);
        q3.push_back('{d: e, c: c});
    endtask

    always @(negedge clk) begin : mon4
        exp_t e;
        if (!reset) begin
            last4 = '0; lch4 = '0;
        end else if (ov4 === 1'b1) begin
            if (q4.size() == 0) begin
                total++; bad++;
                $display("FAIL dut4 unexpected out_valid: got out=%h want no output", out4);
            end else begin
                e = q4.pop_front();
                chk("dut4 out", out4, e.d);
                chk("dut4 ch_idx", ch4, e.c);
                last4 = e.d; lch4 = e.c;
            end
        end else begin
            chk("dut4 hold out", out4, last4);
            chk("dut4 hold ch_idx", ch4, lch4);
        end
    end

    always @(negedge clk) begin : mon3
        exp_t e;
        if (!reset) begin
            last3 = '0; lch3 = '0;
        end else if (ov3 === 1'b1) begin
            if (q3.size() == 0) begin
                total++; bad++;
                $display("FAIL dut3 unexpected out_valid: got out=%h want no output", out3);
            end else begin
                e = q3.pop_front();
                chk("dut3 out", out3, e.d);
                chk("dut3 ch_idx", ch3, e.c);
                last3 = e.d; lch3 = e.c;
            end
        end else begin
            chk("dut3 hold out", out3, last3);
            chk("dut3 hold ch_idx", ch3, lch3);
        end
    end

    logic [15:0] enc_hist [4];
    logic [15:0] d;
    int          c;

    initial begin
        reset = 1'b0;
        vld4 = 0; flush4 = 0; in4 = '0;
        vld3 = 0; flush3 = 0; in3 = '0;
        #12;
        chk("reset out_valid", ov4, 0);
        chk("reset out", out4, 0);
        chk("reset ch_idx", ch4, 0);
        chk("reset dut3 out_valid", ov3, 0);
        @(negedge clk);
        #1 reset = 1'b1;

        // CHANNELS=3: wrap from 2 back to 0
        send3(16'h0001, 16'h0001, 2'd0);
        send3(16'h0002, 16'h0002, 2'd1);
        send3(16'h0003, 16'h0003, 2'd2);
        send3(16'h0005, 16'h0004, 2'd0);
        drive3(1'b0, 1'b0, 16'h0);

        // Basic decode
        send4(1'b0, 16'h0001, 16'h0001, 2'd0);
        send4(1'b0, 16'h0002, 16'h0002, 2'd1);
        send4(1'b0, 16'h0003, 16'h0003, 2'd2);
        send4(1'b0, 16'h0004, 16'h0004, 2'd3);
        send4(1'b0, 16'h0004, 16'h0005, 2'd0);
        send4(1'b0, 16'h0004, 16'h0006, 2'd1);
        send4(1'b0, 16'h0004, 16'h0007, 2'd2);
        send4(1'b0, 16'h000C, 16'h0008, 2'd3);
        drive4(1'b0, 1'b0, 16'h0);
        drive4(1'b0, 1'b0, 16'h0);

        // Gap tolerance after a flush-only restart
        drive4(1'b0, 1'b1, 16'h0);
        send4(1'b0, 16'h0001, 16'h0001, 2'd0);
        send4(1'b0, 16'h0002, 16'h0002, 2'd1);
        send4(1'b0, 16'h0003, 16'h0003, 2'd2);
        send4(1'b0, 16'h0004, 16'h0004, 2'd3);
        repeat (3) drive4(1'b0, 1'b0, 16'h0);
        send4(1'b0, 16'h0004, 16'h0005, 2'd0);
        send4(1'b0, 16'h0004, 16'h0006, 2'd1);
        send4(1'b0, 16'h0004, 16'h0007, 2'd2);
        send4(1'b0, 16'h000C, 16'h0008, 2'd3);
        drive4(1'b0, 1'b0, 16'h0);

        // Flush with valid word
        drive4(1'b0, 1'b1, 16'h0);
        send4(1'b0, 16'h0001, 16'h0001, 2'd0);
        send4(1'b0, 16'h0002, 16'h0002, 2'd1);
        send4(1'b1, 16'h00AA, 16'h00AA, 2'd0);
        send4(1'b0, 16'h0055, 16'h0055, 2'd1);
        drive4(1'b0, 1'b0, 16'h0);

        // Async reset while out_valid is high
        drive4(1'b0, 1'b1, 16'h0);
        send4(1'b0, 16'h0001, 16'h0001, 2'd0);
        send4(1'b0, 16'h0002, 16'h0002, 2'd1);
        drive4(1'b0, 1'b0, 16'h0);
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk("async reset out_valid", ov4, 0);
        chk("async reset out", out4, 0);
        chk("async reset ch_idx", ch4, 0);
        @(negedge clk);
        #1 reset = 1'b1;
        send4(1'b0, 16'h0004, 16'h0004, 2'd0);
        drive4(1'b0, 1'b0, 16'h0);

        // Loopback against a bench-side encoder, with random gaps
        drive4(1'b0, 1'b1, 16'h0);
        for (int i = 0; i < 4; i++) enc_hist[i] = '0;
        c = 0;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                drive4(1'b0, 1'b0, 16'h0);
            end else begin
                d = 16'($urandom);
                send4(1'b0, d ^ enc_hist[c], d, 2'(c));
                enc_hist[c] = d;
                c = (c + 1) % 4;
            end
        end
        drive4(1'b0, 1'b0, 16'h0);

        for (int i = 0; i < 50 && (q4.size() != 0 || q3.size() != 0); i++) @(negedge clk);
        @(negedge clk);
        total++;
        if (q4.size() != 0 || q3.size() != 0) begin
            bad++;
            $display("FAIL drain: got pending=%0d/%0d want 0/0", q4.size(), q3.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
